// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared types and helpers for the PC / return-address-stack
//                unit: the next-PC source select and width helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    // Source of the next PC value
    typedef enum logic [2:0] {
        PC_HOLD   = 3'd0,
        PC_LD_ABS = 3'd1,
        PC_LD_REL = 3'd2,
        PC_RAS    = 3'd3,
        PC_INC    = 3'd4
    } pc_sel_e;

    // Number of low PC bits that must be zero for an aligned PC
    function automatic int align_bits(input int inc_by);
        return (inc_by <= 1) ? 0 : $clog2(inc_by);
    endfunction

    // Width of a counter that must represent 0..depth inclusive
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// ============================================================================
//  Module      : ras_stack
//  Description : Circular return-address stack with top pointer, saturating
//                entry counter and registered overflow/underflow pulse.
//                On overflow the oldest entry is overwritten.
//  Ports       : clk_i, rst_i (async, active high), en_i (advance enable)
//                push_i / pop_i     - push request / pop request
//                push_data_i        - value written on push
//                top_o              - current top entry
//                cnt_o              - number of valid entries
//                empty_o / full_o   - count status
//                err_o              - one-cycle pulse on over/underflow
//  Revision    : 1.0 - initial release
// ============================================================================
module ras_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [WIDTH-1:0]          push_data_i,
    output logic [WIDTH-1:0]          top_o,
    output logic [cnt_w(DEPTH)-1:0]   cnt_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic                      err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    localparam logic [PTR_W-1:0] c_ptr_last = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_ptr;    // next slot to write; top sits just below it
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    logic [PTR_W-1:0] w_top_idx;
    logic [PTR_W-1:0] w_ptr_inc;
    logic [PTR_W-1:0] w_wr_idx;
    logic             w_empty;
    logic             w_full;
    logic             w_pop_eff;
    logic             w_push_only;

    assign w_empty     = (r_cnt == '0);
    assign w_full      = (r_cnt == c_cnt_full);

    // Explicit wrap so DEPTH need not be a power of two
    assign w_top_idx   = (r_ptr == '0) ? c_ptr_last : (r_ptr - PTR_W'(1));
    assign w_ptr_inc   = (r_ptr == c_ptr_last) ? '0 : (r_ptr + PTR_W'(1));

    assign w_pop_eff   = pop_i & ~w_empty;
    assign w_push_only = push_i & ~w_pop_eff;

    // Push+pop together replaces the top in place; a plain push writes the
    // next slot (which is the oldest entry when full).
    assign w_wr_idx    = w_pop_eff ? w_top_idx : r_ptr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (en_i) begin
            r_err <= (pop_i & w_empty) | (w_push_only & w_full);
            if (w_push_only) begin
                r_ptr <= w_ptr_inc;
                if (!w_full) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else if (w_pop_eff && !push_i) begin
                r_ptr <= w_top_idx;
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end else begin
            r_err <= 1'b0;
        end
    end

    // Entry storage carries no reset: contents are meaningless until pushed
    always_ff @(posedge clk_i) begin
        if (en_i && push_i) begin
            r_mem[w_wr_idx] <= push_data_i;
        end
    end

    assign top_o   = r_mem[w_top_idx];
    assign cnt_o   = r_cnt;
    assign empty_o = w_empty;
    assign full_o  = w_full;
    assign err_o   = r_err;

endmodule
`default_nettype wire

// File: rtl/pc_ras_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_ras_unit
//  Description : Fetch program counter with hold, absolute load, relative
//                load, sequential increment and an integrated return-address
//                stack for call/return redirects.
//  Ports       : clk_i, rst_i (async, active high), en_i (advance enable)
//                ld_ct_i, d_r_i, ld_i - load control, mode (1=abs), operand
//                push_i / pop_i       - call / return
//                pc_o                 - registered PC
//                is_aligned_o         - low align bits of pc_o are zero
//                ras_cnt_o, ras_empty_o, ras_full_o, ras_err_o - RAS status
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_ras_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               INC_BY    = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               RAS_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          en_i,
    input  logic                          ld_ct_i,
    input  logic                          d_r_i,
    input  logic [WIDTH-1:0]              ld_i,
    input  logic                          push_i,
    input  logic                          pop_i,
    output logic [WIDTH-1:0]              pc_o,
    output logic                          is_aligned_o,
    output logic [cnt_w(RAS_DEPTH)-1:0]   ras_cnt_o,
    output logic                          ras_empty_o,
    output logic                          ras_full_o,
    output logic                          ras_err_o
);

    localparam int ALIGN_W = align_bits(INC_BY);

    localparam logic [WIDTH-1:0] c_inc = WIDTH'(INC_BY);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_ret_addr;
    logic [WIDTH-1:0] w_ras_top;
    logic             w_ras_pop;
    pc_sel_e          w_sel;

    assign w_ret_addr = r_pc + c_inc;

    // A load in the same cycle cancels the return entirely
    assign w_ras_pop  = pop_i & ~ld_ct_i;

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras_stack (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .push_i      (push_i),
        .pop_i       (w_ras_pop),
        .push_data_i (w_ret_addr),
        .top_o       (w_ras_top),
        .cnt_o       (ras_cnt_o),
        .empty_o     (ras_empty_o),
        .full_o      (ras_full_o),
        .err_o       (ras_err_o)
    );

    always_comb begin
        w_sel = PC_HOLD;
        if (en_i) begin
            if (ld_ct_i) begin
                w_sel = d_r_i ? PC_LD_ABS : PC_LD_REL;
            end else if (pop_i && !ras_empty_o) begin
                w_sel = PC_RAS;
            end else begin
                w_sel = PC_INC;
            end
        end
    end

    always_comb begin
        w_pc_next = r_pc;
        case (w_sel)
            PC_LD_ABS: w_pc_next = ld_i;
            PC_LD_REL: w_pc_next = r_pc + ld_i;   // wraps modulo 2^WIDTH
            PC_RAS:    w_pc_next = w_ras_top;
            PC_INC:    w_pc_next = w_ret_addr;
            default:   w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc <= RESET_VEC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign pc_o = r_pc;

    generate
        if (ALIGN_W == 0) begin : g_align_none
            assign is_aligned_o = 1'b1;
        end else begin : g_align_chk
            assign is_aligned_o = (r_pc[ALIGN_W-1:0] == '0);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pc_ras_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_ras_unit
//  Description : Self-checking bench for pc_ras_unit (default parameters).
//                A queue-based reference model tracks PC and return stack;
//                outputs are compared on every falling edge, plus literal
//                checks that pin the model at key points.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_ras_unit;

    localparam int DEPTH = 4;
    localparam int INC   = 4;

    logic        clk_i   = 1'b0;
    logic        rst_i   = 1'b1;
    logic        en_i    = 1'b0;
    logic        ld_ct_i = 1'b0;
    logic        d_r_i   = 1'b0;
    logic [31:0] ld_i    = '0;
    logic        push_i  = 1'b0;
    logic        pop_i   = 1'b0;
    logic [31:0] pc_o;
    logic        is_aligned_o;
    logic [2:0]  ras_cnt_o;
    logic        ras_empty_o;
    logic        ras_full_o;
    logic        ras_err_o;

    pc_ras_unit dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .ld_ct_i      (ld_ct_i),
        .d_r_i        (d_r_i),
        .ld_i         (ld_i),
        .push_i       (push_i),
        .pop_i        (pop_i),
        .pc_o         (pc_o),
        .is_aligned_o (is_aligned_o),
        .ras_cnt_o    (ras_cnt_o),
        .ras_empty_o  (ras_empty_o),
        .ras_full_o   (ras_full_o),
        .ras_err_o    (ras_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model state
    logic [31:0] m_pc  = '0;
    logic [31:0] m_q[$];
    logic        m_err = 1'b0;
    bit          chk_on = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; model advances at the same edge as the DUT
    task automatic cyc(input bit en, input bit ldct, input bit dr, input logic [31:0] ld,
                       input bit push, input bit pop);
        logic [31:0] np;
        logic [31:0] ret;
        bit          eff_pop;
        bit          nerr;
        en_i = en; ld_ct_i = ldct; d_r_i = dr; ld_i = ld; push_i = push; pop_i = pop;
        eff_pop = pop && !ldct && (m_q.size() > 0);
        ret     = m_pc + 32'(INC);
        if (ldct && dr)  np = ld;
        else if (ldct)   np = m_pc + ld;
        else if (eff_pop) np = m_q[m_q.size()-1];
        else             np = ret;
        nerr = (pop && !ldct && m_q.size() == 0) || (push && !eff_pop && m_q.size() == DEPTH);
        @(posedge clk_i);
        if (!en) begin
            m_err = 1'b0;
        end else begin
            if (push && eff_pop) begin
                m_q[m_q.size()-1] = ret;
            end else if (push) begin
                if (m_q.size() == DEPTH) void'(m_q.pop_front());
                m_q.push_back(ret);
            end else if (eff_pop) begin
                void'(m_q.pop_back());
            end
            m_pc  = np;
            m_err = nerr;
        end
        #1;
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic load_abs(input logic [31:0] v);
        cyc(1'b1, 1'b1, 1'b1, v, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        m_pc  = '0;
        m_err = 1'b0;
        m_q.delete();
    endtask

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk_i);
            if (chk_on) begin
                chk("pc", pc_o, m_pc);
                chk("aligned", 32'(is_aligned_o), 32'((m_pc % INC) == 0));
                chk("cnt", 32'(ras_cnt_o), 32'(m_q.size()));
                chk("empty", 32'(ras_empty_o), 32'(m_q.size() == 0));
                chk("full", 32'(ras_full_o), 32'(m_q.size() == DEPTH));
                chk("err", 32'(ras_err_o), 32'(m_err));
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk_on = 1'b1;
        rst_i  = 1'b0;
        chk("lit_reset_pc", pc_o, 32'h0);
        chk("lit_reset_cnt", 32'(ras_cnt_o), 32'h0);

        // Reset and increment
        idle(); chk("lit_inc1", pc_o, 32'h4);
        idle(); chk("lit_inc2", pc_o, 32'h8);
        idle(); chk("lit_inc3", pc_o, 32'hC);
        chk("lit_aligned", 32'(is_aligned_o), 32'h1);
        rst_i = 1'b1;
        model_reset();
        #1;
        chk("lit_async_rst", pc_o, 32'h0);
        #1;
        rst_i = 1'b0;

        // Loads and hold
        load_abs(32'h1);
        chk("lit_ld_abs", pc_o, 32'h1);
        chk("lit_misaligned", 32'(is_aligned_o), 32'h0);
        load_abs(32'h100);
        cyc(1'b1, 1'b1, 1'b0, 32'hFFFF_FFF0, 1'b0, 1'b0);
        chk("lit_ld_rel_neg", pc_o, 32'hF0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            chk("lit_hold", pc_o, 32'hF0);
        end
        // Enable low must also freeze controls that would otherwise act
        cyc(1'b0, 1'b1, 1'b1, 32'h888, 1'b1, 1'b0);
        chk("lit_hold_ctl", pc_o, 32'hF0);

        // Call and return
        load_abs(32'h20);
        cyc(1'b1, 1'b1, 1'b1, 32'h400, 1'b1, 1'b0);
        chk("lit_call_pc", pc_o, 32'h400);
        chk("lit_call_cnt", 32'(ras_cnt_o), 32'h1);
        idle(); idle();
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("lit_ret_pc", pc_o, 32'h24);
        chk("lit_ret_empty", 32'(ras_empty_o), 32'h1);

        // Overflow
        load_abs(32'h0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
            chk("lit_ovf_err", 32'(ras_err_o), (i == 4) ? 32'h1 : 32'h0);
        end
        chk("lit_ovf_full", 32'(ras_full_o), 32'h1);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp_ret [4];
            exp_ret = '{32'h14, 32'h10, 32'hC, 32'h8};
            cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            chk("lit_ovf_pop", pc_o, exp_ret[i]);
        end
        chk("lit_ovf_drained", 32'(ras_cnt_o), 32'h0);

        // Underflow
        load_abs(32'h50);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("lit_unf_pc", pc_o, 32'h54);
        chk("lit_unf_err", 32'(ras_err_o), 32'h1);
        idle();
        chk("lit_unf_err_clr", 32'(ras_err_o), 32'h0);

        // Simultaneous controls
        load_abs(32'h1FC);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);     // pushes 0x200
        load_abs(32'h60);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);     // swap top
        chk("lit_pushpop_pc", pc_o, 32'h200);
        chk("lit_pushpop_cnt", 32'(ras_cnt_o), 32'h1);
        cyc(1'b1, 1'b1, 1'b1, 32'h300, 1'b0, 1'b1);   // load beats pop
        chk("lit_ldpop_pc", pc_o, 32'h300);
        chk("lit_ldpop_cnt", 32'(ras_cnt_o), 32'h1);
        chk("lit_ldpop_err", 32'(ras_err_o), 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("lit_new_top", pc_o, 32'h64);
        load_abs(32'hFFFF_FFFC);
        cyc(1'b1, 1'b1, 1'b0, 32'h8, 1'b0, 1'b0);
        chk("lit_rel_wrap", pc_o, 32'h4);
        load_abs(32'hFFFF_FFFC);
        idle();
        chk("lit_inc_wrap", pc_o, 32'h0);

        // Reset mid-operation clears the stack
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        rst_i = 1'b1;
        model_reset();
        #1;
        chk("lit_rst_cnt", 32'(ras_cnt_o), 32'h0);
        #1;
        rst_i = 1'b0;
        idle(); idle();

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
Parametrised program-counter unit for the uarch simulator core. Generates the fetch PC from a reset vector, and supports hold, absolute load, PC-relative load, and sequential increment. Adds an integrated return-address stack (RAS) so call/return redirects resolve in the PC stage. The fetch stage consumes `pc_o`; the decode/branch logic drives the load, push and pop controls.

Parameters:
- `WIDTH`, 32, PC and load-operand width in bits.
- `INC_BY`, 4, sequential increment in bytes; must be a power of two, at least 1.
- `RESET_VEC`, 0, PC value taken on reset.
- `RAS_DEPTH`, 4, number of RAS entries; must be at least 2.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `en_i`  in  1  advance enable; when 0, all state holds.
- `ld_ct_i`  in  1  load PC this cycle.
- `d_r_i`  in  1  load mode: 1 = direct (absolute), 0 = relative to current `pc_o`.
- `ld_i`  in  WIDTH  load target (direct) or signed two's-complement offset (relative).
- `push_i`  in  1  call: push `pc_o`+`INC_BY` onto the RAS.
- `pop_i`  in  1  return: redirect PC to the RAS top and pop it.
- `pc_o`  out  WIDTH  current PC, registered.
- `is_aligned_o`  out  1  high when the low `$clog2(INC_BY)` bits of `pc_o` are zero; constant 1 when `INC_BY`=1.
- `ras_cnt_o`  out  `$clog2(RAS_DEPTH+1)`  number of valid RAS entries.
- `ras_empty_o`  out  1  `ras_cnt_o`==0.
- `ras_full_o`  out  1  `ras_cnt_o`==`RAS_DEPTH`.
- `ras_err_o`  out  1  registered one-cycle pulse on RAS underflow or overflow.

Behaviour:
- **Reset (asynchronous).**
  - `pc_o`=`RESET_VEC`, `ras_cnt_o`=0, `ras_err_o`=0, RAS pointer=0.
  - RAS entry contents are don't-care.
  - Reset asserted mid-operation overrides everything immediately, with no clock required.
- **Enable low.** When `en_i`=0, `pc_o`, the RAS and `ras_cnt_o` hold, and `ras_err_o` is driven 0 on the next edge.
- **Next-PC priority when `en_i`=1, highest first:**
  1. `ld_ct_i`=1 and `d_r_i`=1: `pc_o` <= `ld_i`.
  2. `ld_ct_i`=1 and `d_r_i`=0: `pc_o` <= `pc_o` + `ld_i`, wrapping modulo 2^`WIDTH`.
  3. `pop_i`=1 and RAS not empty: `pc_o` <= RAS top.
  4. Otherwise: `pc_o` <= `pc_o` + `INC_BY`, wrapping modulo 2^`WIDTH` (all-ones + `INC_BY` wraps to the low values).
- **Latency.** Every update takes effect one cycle after the sampling edge. There is no combinational path from any input to `pc_o`.
- **RAS organisation.** Circular buffer with a top pointer; `ras_cnt_o` saturates at `RAS_DEPTH`.
- **Push only** (`push_i`=1, no effective pop):
  - The value written is the pre-update `pc_o`+`INC_BY`.
  - If the RAS is not full: write, advance the pointer, `ras_cnt_o`+1.
  - If the RAS is full: overwrite the oldest entry, advance the pointer, keep the count, and pulse `ras_err_o` (overflow).
- **Pop when not empty** (no push): the top drives `pc_o` per the priority list, the pointer retreats, and `ras_cnt_o`-1.
- **Pop when empty:** `ras_err_o` pulses (underflow), the PC follows lower-priority rules (increment), and the count stays 0.
- **Push and pop in the same cycle, RAS not empty:**
  - The PC takes the top.
  - The top entry is replaced by `pc_o`+`INC_BY`.
  - The count and pointer are unchanged.
- **`ld_ct_i`=1 together with `pop_i`=1:** the load wins. The pop is ignored entirely (no pointer or count change, no error). A `push_i` in the same cycle is still honoured, which is how a call is formed.
- **`is_aligned_o`** is combinational from `pc_o` only. A misaligned direct load is accepted as-is and flagged on this output; no fault is raised.

Decomposition:
- **Shared package** `pc_pkg` holds:
  - the next-PC source select enum (`PC_HOLD`, `PC_LD_ABS`, `PC_LD_REL`, `PC_RAS`, `PC_INC`);
  - the function `align_bits(INC_BY)`;
  - the function `cnt_w(RAS_DEPTH)`.
- **Sub-module** `ras_stack` (parameters `WIDTH`, `DEPTH`) contains the circular buffer, pointer, counter and overflow/underflow detection. `pc_ras_unit` contains the next-PC mux and the PC register.

Test Plan:
Default parameters unless noted.
1. **Reset and increment.** Hold `rst_i`, release with `en_i`=1 and no controls -> `pc_o` = 0, 4, 8, 12 on successive edges; `is_aligned_o`=1. Assert `rst_i` between edges -> `pc_o`=0 immediately.
2. **Loads and hold.**
   - Direct load of 0x1 -> `pc_o`=0x1, `is_aligned_o`=0.
   - From `pc_o`=0x100, relative load with `ld_i`=0xFFFFFFF0 -> 0xF0.
   - `en_i`=0 for 3 cycles -> `pc_o` constant.
3. **Call and return.** At `pc_o`=0x20, `ld_ct_i`+`d_r_i`+`push_i` with `ld_i`=0x400 -> `pc_o`=0x400, `ras_cnt_o`=1. Two increments, then `pop_i` -> `pc_o`=0x24, `ras_cnt_o`=0, `ras_empty_o`=1.
4. **Overflow.** 5 pushes from PCs 0x0, 0x4, 0x8, 0xC, 0x10 -> `ras_err_o` pulses once on the 5th push, `ras_full_o`=1. Then 4 pops return PCs 0x14, 0x10, 0xC, 0x8.
5. **Underflow.** `pop_i` with the RAS empty at `pc_o`=0x50 -> `pc_o`=0x54, `ras_err_o`=1 for exactly one cycle, `ras_cnt_o`=0.
6. **Simultaneous controls.**
   - `push_i`+`pop_i` with top=0x200 at `pc_o`=0x60 -> `pc_o`=0x200, top becomes 0x64, count unchanged.
   - `ld_ct_i`+`pop_i` -> load taken, count unchanged.
   - Relative load from 0xFFFFFFFC with `ld_i`=8 -> `pc_o`=0x4.
